// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared waveform codes and default widths for the DDS generator
package dds_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

endpackage

// File: rtl/dds_sine_lut.sv
// rtl/dds_sine_lut.sv - quarter-wave sine ROM with one-cycle registered read
module dds_sine_lut
    import dds_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W - 2,
    parameter int DATA_W = DEF_DATA_W - 1
)(
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    // Entries are sampled at half-step offsets so the quarter folds symmetrically.
    function automatic logic [DATA_W-1:0] sine_entry(input int k);
        real x;
        x = (2.0 ** DATA_W - 1.0) * $sin(3.14159265358979 / 2.0 * (k + 0.5) / (2.0 ** ADDR_W));
        return DATA_W'($rtoi(x + 0.5));
    endfunction

    logic [DATA_W-1:0] w_rom [2**ADDR_W];
    logic [DATA_W-1:0] r_data;

    for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_rom
        localparam logic [DATA_W-1:0] ENTRY = sine_entry(k);
        assign w_rom[k] = ENTRY;
    end

    always_ff @(posedge i_clk) begin
        r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/dds_gen.sv
// rtl/dds_gen.sv - DDS waveform generator: phase accumulator, 3-stage shaper, shadowed config
module dds_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
)(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fword,
    input  logic [ADDR_W-1:0]  cfg_poff,
    input  logic [1:0]         cfg_wave,
    input  logic [DATA_W:0]    cfg_amp,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_vld,
    output logic               phase_wrap
);

    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   AMP_UNITY = {1'b1, {DATA_W{1'b0}}};

    logic [PHASE_W-1:0] r_sh_fword, r_fword, r_acc;
    logic [ADDR_W-1:0]  r_sh_poff, r_poff;
    logic [1:0]         r_sh_wave, r_wave;
    logic [DATA_W:0]    r_sh_amp, r_amp;
    logic               r_pending, r_ready, r_wrap;
    logic [PHASE_W:0]   w_sum;
    logic               w_accept, w_commit;
    logic [DATA_W:0]    w_amp_clamped;

    assign w_sum         = {1'b0, r_acc} + {1'b0, r_fword};
    assign w_accept      = cfg_valid && r_ready;
    // While running, config only swaps on the carry so a period is never split.
    assign w_commit      = r_pending && (!en || w_sum[PHASE_W]);
    assign w_amp_clamped = cfg_amp[DATA_W] ? AMP_UNITY : cfg_amp;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sh_fword <= '0;
            r_sh_poff  <= '0;
            r_sh_wave  <= WAVE_SINE;
            r_sh_amp   <= AMP_UNITY;
            r_fword    <= '0;
            r_poff     <= '0;
            r_wave     <= WAVE_SINE;
            r_amp      <= AMP_UNITY;
            r_pending  <= 1'b0;
            r_ready    <= 1'b0;
        end else if (w_accept) begin
            r_sh_fword <= cfg_fword;
            r_sh_poff  <= cfg_poff;
            r_sh_wave  <= cfg_wave;
            r_sh_amp   <= w_amp_clamped;
            r_pending  <= 1'b1;
            r_ready    <= 1'b0;
        end else if (w_commit) begin
            r_fword    <= r_sh_fword;
            r_poff     <= r_sh_poff;
            r_wave     <= r_sh_wave;
            r_amp      <= r_sh_amp;
            r_pending  <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_ready    <= !r_pending;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_acc  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= en && w_sum[PHASE_W];
            if (en) begin
                r_acc <= w_sum[PHASE_W-1:0];
            end
        end
    end

    // Stage 1: phase address; wave/amp travel with the sample they belong to.
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_wave1, r_wave2;
    logic [DATA_W:0]   r_amp1, r_amp2;
    logic              r_en1, r_en2, r_neg2, r_vld;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_addr  <= '0;
            r_wave1 <= WAVE_SINE;
            r_amp1  <= AMP_UNITY;
            r_en1   <= 1'b0;
        end else begin
            r_addr  <= r_acc[PHASE_W-1 -: ADDR_W] + r_poff;
            r_wave1 <= r_wave;
            r_amp1  <= r_amp;
            r_en1   <= en;
        end
    end

    // Stage 2: quarter-wave lookup folded by quadrant, plus the piecewise-linear shapes.
    logic [ADDR_W-3:0] w_i, w_lut_addr;
    logic [DATA_W-2:0] w_m;
    logic [DATA_W-1:0] w_tri, w_shape, r_shape2, w_raw;

    assign w_i        = r_addr[ADDR_W-3:0];
    assign w_lut_addr = r_addr[ADDR_W-2] ? ~w_i : w_i;
    assign w_tri      = r_addr[ADDR_W-2 -: DATA_W];

    dds_sine_lut #(
        .ADDR_W (ADDR_W - 2),
        .DATA_W (DATA_W - 1)
    ) u_sine_lut (
        .i_clk  (sys_clk),
        .i_addr (w_lut_addr),
        .o_data (w_m)
    );

    always_comb begin
        w_shape = '0;
        case (r_wave1)
            WAVE_SQUARE: w_shape = {DATA_W{~r_addr[ADDR_W-1]}};
            WAVE_TRI:    w_shape = r_addr[ADDR_W-1] ? ~w_tri : w_tri;
            WAVE_SAW:    w_shape = r_addr[ADDR_W-1 -: DATA_W];
            default:     w_shape = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_shape2 <= '0;
            r_wave2  <= WAVE_SINE;
            r_amp2   <= AMP_UNITY;
            r_neg2   <= 1'b0;
            r_en2    <= 1'b0;
        end else begin
            r_shape2 <= w_shape;
            r_wave2  <= r_wave1;
            r_amp2   <= r_amp1;
            r_neg2   <= r_addr[ADDR_W-1];
            r_en2    <= r_en1;
        end
    end

    assign w_raw = (r_wave2 != WAVE_SINE) ? r_shape2 :
                   r_neg2 ? (MID - DATA_W'(1) - {1'b0, w_m}) : (MID + {1'b0, w_m});

    // Stage 3: gain about midscale; |s*amp| >> DATA_W never exceeds half range.
    logic signed [DATA_W:0]     w_s;
    logic signed [2*DATA_W+1:0] w_prod;
    logic [DATA_W-1:0]          w_scaled, r_wave_out;

    assign w_s      = $signed({1'b0, w_raw}) - $signed({1'b0, MID});
    assign w_prod   = w_s * $signed({1'b0, r_amp2});
    assign w_scaled = DATA_W'(w_prod >>> DATA_W);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wave_out <= MID;
            r_vld      <= 1'b0;
        end else begin
            r_vld <= r_en2;
            if (r_en2) begin
                r_wave_out <= MID + w_scaled;
            end
        end
    end

    assign cfg_ready  = r_ready;
    assign wave_out   = r_wave_out;
    assign wave_vld   = r_vld;
    assign phase_wrap = r_wrap;

endmodule

// File: tb/tb_dds_gen.sv
// tb/tb_dds_gen.sv - directed self-checking bench for dds_gen
module tb_dds_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_fword = '0;
    logic [9:0]  cfg_poff = '0;
    logic [1:0]  cfg_wave = '0;
    logic [8:0]  cfg_amp = 9'd256;
    logic [7:0]  wave_out;
    logic        wave_vld;
    logic        phase_wrap;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] amp_tab [4] = '{9'd256, 9'd128, 9'd0, 9'd511};
    logic [7:0] hi_tab  [4] = '{8'd255, 8'd191, 8'd128, 8'd255};
    logic [7:0] lo_tab  [4] = '{8'd0,   8'd64,  8'd128, 8'd0};
    logic [7:0] tri_tab [8] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd255, 8'd191, 8'd127, 8'd63};

    dds_gen #(.PHASE_W(32), .ADDR_W(10), .DATA_W(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_fword  (cfg_fword),
        .cfg_poff   (cfg_poff),
        .cfg_wave   (cfg_wave),
        .cfg_amp    (cfg_amp),
        .wave_out   (wave_out),
        .wave_vld   (wave_vld),
        .phase_wrap (phase_wrap)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic do_reset();
        sys_rst = 1'b1; en = 1'b1; cfg_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0; en = 1'b0;
    endtask

    task automatic offer(input logic [1:0] wave, input logic [31:0] fword,
                         input logic [9:0] poff, input logic [8:0] amp);
        cfg_wave = wave; cfg_fword = fword; cfg_poff = poff; cfg_amp = amp; cfg_valid = 1'b1;
        for (int t = 0; t < 40 && cfg_ready !== 1'b1; t++) @(negedge sys_clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfg_offer_timeout: cfg_ready=%b want 1", cfg_ready); end
        @(posedge sys_clk);
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [1:0] wave, input logic [31:0] fword,
                            input logic [9:0] poff, input logic [8:0] amp);
        offer(wave, fword, poff, amp);
        @(negedge sys_clk);
    endtask

    task automatic start_run();
        en = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; en = 1'b1; cfg_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (wave_out !== 8'd128) begin n_err++; $display("FAIL rst_wave_out: got %0d want 128", wave_out); end
        n_cmp++; if (wave_vld !== 1'b0) begin n_err++; $display("FAIL rst_wave_vld: got %b want 0", wave_vld); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); end
        n_cmp++; if (phase_wrap !== 1'b0) begin n_err++; $display("FAIL rst_phase_wrap: got %b want 0", phase_wrap); end
        sys_rst = 1'b0; en = 1'b0;
        @(negedge sys_clk);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_saw();
        int wraps;
        logic [7:0] exp_v;
        wraps = 0;
        do_reset();
        load_cfg(2'd3, 32'd1 << 22, 10'd0, 9'd256);
        en = 1'b1;
        for (int n = 1; n <= 2060; n++) begin
            @(negedge sys_clk);
            if (phase_wrap === 1'b1) wraps++;
            if (n >= 3 && n < 19) begin
                exp_v = 8'((n - 3) / 4);
                n_cmp++;
                if (wave_out !== exp_v || wave_vld !== 1'b1) begin
                    n_err++; $display("FAIL saw_sample_%0d: got %0d vld %b want %0d vld 1", n - 3, wave_out, wave_vld, exp_v);
                end
            end
            if (n == 1023 || n == 1024 || n == 2048 || n == 2049) begin
                n_cmp++;
                if (phase_wrap !== (n == 1024 || n == 2048)) begin
                    n_err++; $display("FAIL saw_wrap_at_%0d: got %b want %b", n, phase_wrap, (n == 1024 || n == 2048));
                end
            end
        end
        n_cmp++; if (wraps != 2) begin n_err++; $display("FAIL saw_wrap_count: got %0d want 2", wraps); end
        en = 1'b0;
    endtask

    task automatic test_square_amp();
        for (int a = 0; a < 4; a++) begin
            do_reset();
            load_cfg(2'd1, 32'h8000_0000, 10'd0, amp_tab[a]);
            start_run();
            n_cmp++; if (wave_out !== hi_tab[a]) begin n_err++; $display("FAIL sq_amp%0d_k0: got %0d want %0d", amp_tab[a], wave_out, hi_tab[a]); end
            @(negedge sys_clk);
            n_cmp++; if (wave_out !== lo_tab[a]) begin n_err++; $display("FAIL sq_amp%0d_k1: got %0d want %0d", amp_tab[a], wave_out, lo_tab[a]); end
            en = 1'b0;
            repeat (5) @(negedge sys_clk);
            n_cmp++;
            if (wave_out !== lo_tab[a] || wave_vld !== 1'b0) begin
                n_err++; $display("FAIL sq_amp%0d_hold: got %0d vld %b want %0d vld 0", amp_tab[a], wave_out, wave_vld, lo_tab[a]);
            end
        end
    endtask

    task automatic test_triangle();
        do_reset();
        load_cfg(2'd2, 32'd1 << 29, 10'd0, 9'd256);
        start_run();
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (wave_out !== tri_tab[k]) begin n_err++; $display("FAIL tri_k%0d: got %0d want %0d", k, wave_out, tri_tab[k]); end
            @(negedge sys_clk);
        end
        en = 1'b0;
    endtask

    task automatic test_sine_offset();
        do_reset();
        load_cfg(2'd0, 32'd0, 10'd256, 9'd256);
        start_run();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (wave_out !== 8'd255 || wave_vld !== 1'b1) begin
                n_err++; $display("FAIL sine_peak_k%0d: got %0d vld %b want 255 vld 1", k, wave_out, wave_vld);
            end
            @(negedge sys_clk);
        end
        en = 1'b0;
        load_cfg(2'd0, 32'd0, 10'd768, 9'd256);
        start_run();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (wave_out !== 8'd0) begin n_err++; $display("FAIL sine_trough_k%0d: got %0d want 0", k, wave_out); end
            @(negedge sys_clk);
        end
        en = 1'b0;
    endtask

    task automatic test_cfg_handshake();
        logic wrapped;
        int   bad_ready, gap;
        wrapped = 1'b0; bad_ready = 0; gap = 0;
        do_reset();
        load_cfg(2'd0, 32'd1 << 22, 10'd0, 9'd256);
        start_run();
        n_cmp++; if (wave_out !== 8'd128) begin n_err++; $display("FAIL sine_k0: got %0d want 128", wave_out); end
        repeat (8) @(negedge sys_clk);
        n_cmp++; if (wave_out !== 8'd135) begin n_err++; $display("FAIL sine_k8: got %0d want 135", wave_out); end
        repeat (300) @(negedge sys_clk);
        offer(2'd0, 32'd1 << 23, 10'd0, 9'd256);
        for (int n = 0; n < 1100 && !wrapped; n++) begin
            cfg_fword = 32'd1 << 24;
            cfg_valid = (n >= 2 && n < 6);
            @(negedge sys_clk);
            if (phase_wrap === 1'b1) wrapped = 1'b1;
            else if (cfg_ready !== 1'b0) bad_ready++;
        end
        cfg_valid = 1'b0;
        n_cmp++; if (wrapped !== 1'b1) begin n_err++; $display("FAIL hs_wrap_timeout: wrapped=%b want 1", wrapped); end
        n_cmp++; if (bad_ready != 0) begin n_err++; $display("FAIL hs_ready_while_pending: high %0d cycles want 0", bad_ready); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_at_wrap: got %b want 1", cfg_ready); end
        for (int n = 1; n <= 600; n++) begin
            @(negedge sys_clk);
            if (phase_wrap === 1'b1) begin gap = n; break; end
        end
        n_cmp++; if (gap != 512) begin n_err++; $display("FAIL hs_new_period: got %0d want 512", gap); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL hs_second_offer_ignored: ready %b want 1", cfg_ready); end
        en = 1'b0;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        load_cfg(2'd0, 32'd1 << 22, 10'd0, 9'd256);
        en = 1'b1;
        repeat (300) @(negedge sys_clk);
        offer(2'd3, 32'd1 << 23, 10'd0, 9'd256);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_cmp++; if (wave_out !== 8'd128) begin n_err++; $display("FAIL mid_rst_wave_out: got %0d want 128", wave_out); end
        n_cmp++; if (wave_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_vld: got %b want 0", wave_vld); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", cfg_ready); end
        n_cmp++; if (phase_wrap !== 1'b0) begin n_err++; $display("FAIL mid_rst_wrap: got %b want 0", phase_wrap); end
        sys_rst = 1'b0; en = 1'b0;
        @(negedge sys_clk);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_release_ready: got %b want 1", cfg_ready); end
        @(negedge sys_clk);
        start_run();
        n_cmp++;
        if (wave_out !== 8'd128 || wave_vld !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_discard_k0: got %0d vld %b want 128 vld 1", wave_out, wave_vld);
        end
        repeat (8) @(negedge sys_clk);
        n_cmp++; if (wave_out !== 8'd128) begin n_err++; $display("FAIL mid_rst_discard_k8: got %0d want 128", wave_out); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_saw();
        test_square_amp();
        test_triangle();
        test_sine_offset();
        test_cfg_handshake();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dds_gen.md
DDS_GEN -- requirements
Module: dds_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, phase accumulator and tuning-word width.
REQ-002 SHALL have parameter ADDR_W, default 10, full-cycle phase address width (quarter-wave LUT depth 2^(ADDR_W-2)).
REQ-003 SHALL have parameter DATA_W, default 8, output sample width, offset-binary (midscale 2^(DATA_W-1)).
REQ-004 SHALL have ports:
  - sys_clk  in  1  sole clock.
  - sys_rst  in  1  reset; synchronous, active-high.
  - en  in  1  run; accumulator advances while high.
  - cfg_valid  in  1  config offered.
  - cfg_ready  out  1  shadow register free.
  - cfg_fword  in  PHASE_W  frequency tuning word.
  - cfg_poff  in  ADDR_W  phase offset in address units.
  - cfg_wave  in  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
  - cfg_amp  in  DATA_W+1  gain; 2^DATA_W = unity; larger values clamp to 2^DATA_W.
  - wave_out  out  DATA_W  sample to DAC.
  - wave_vld  out  1  wave_out carries a live sample.
  - phase_wrap  out  1  one-cycle pulse on accumulator carry-out.

Function
REQ-005 SHALL capture cfg_* into a shadow register on cycles where cfg_valid && cfg_ready, then set pending and drive cfg_ready low.
REQ-006 SHALL copy shadow to active config, clear pending, and raise cfg_ready the next cycle, on whichever comes first: en=0 with pending (next cycle), or the cycle acc carries out with en=1. No partial-period config change SHALL occur while running.
REQ-007 SHALL use the active fword for the carry cycle's add; the new fword takes effect from the following cycle.
REQ-008 SHALL compute acc <= acc + fword (mod 2^PHASE_W) each cycle en=1, and hold acc when en=0; phase_wrap = carry-out of that add, registered.
REQ-009 Stage 1 SHALL form addr = acc[PHASE_W-1 -: ADDR_W] + poff (mod 2^ADDR_W).
REQ-010 Stage 2 SHALL form raw sample r (DATA_W bits), with q = addr[ADDR_W-1:ADDR_W-2] and i = addr[ADDR_W-3:0]:
  - sine: m = LUT[i] for q=0/2, LUT[~i] for q=1/3; r = mid+m for q<2, mid-1-m otherwise.
  - square: r = all-ones if addr MSB=0, else 0.
  - triangle: t = addr[ADDR_W-2 -: DATA_W]; r = t if MSB=0, else ~t.
  - sawtooth: r = addr[ADDR_W-1 -: DATA_W].
REQ-011 Stage 3 SHALL compute s = r - mid (signed), wave_out = mid + ((s * amp) >>> DATA_W), arithmetic shift, no overflow possible.
REQ-012 Latency acc-to-wave_out SHALL be exactly 3 cycles; wave_vld SHALL equal en delayed 3 cycles.
REQ-013 While wave_vld=0, wave_out SHALL hold its last value.
REQ-014 LUT entry k SHALL be round((2^(DATA_W-1)-1)*sin(pi/2*(k+0.5)/2^(ADDR_W-2))), constant ROM.
REQ-015 cfg_valid with cfg_ready=0 SHALL be ignored; the source holds data until accepted.

Reset
REQ-016 sys_rst SHALL be sampled on sys_clk only; any cycle it is high overrides all other activity, including mid-pipeline and pending config.
REQ-017 Reset values: acc 0; active/shadow fword 0, poff 0, wave sine, amp 2^DATA_W; pending 0; cfg_ready 0 during reset, 1 first cycle after; wave_out mid; wave_vld 0; phase_wrap 0; pipeline flushed.

Structure
REQ-018 Package dds_pkg SHALL hold the waveform-code constants/enum and default parameter values.
REQ-019 Sine ROM SHALL be sub-module dds_sine_lut (registered read, 1 cycle, part of stage 2).
REQ-020 Shadow/active config and handshake SHALL live in dds_gen; no other sub-modules.

Verification (DATA_W=8, ADDR_W=10, PHASE_W=32)
REQ-021 Reset for 3 cycles with en=1 -> wave_out=128, wave_vld=0, cfg_ready=0; cfg_ready=1 first cycle after release.
REQ-022 Load saw, fword=2^22, amp=256, en=1 -> after 3 cycles wave_out steps 0,0,0,0,1,... rising every 4 cycles; phase_wrap every 1024 cycles.
REQ-023 Square, fword=2^31, amp=256 -> wave_out alternates 255/0 each cycle; amp=128 -> 191/64; amp=0 -> constant 128; amp=511 -> same as 256.
REQ-024 Running sine, fword=2^22; offer new fword mid-period -> cfg_ready low until carry cycle; fword changes exactly after phase_wrap; one further offer during pending is not accepted.
REQ-025 Sine, poff=256, fword=0, en=1 -> wave_out constant 255 (peak, LUT[255]=127); poff=768 -> 0.
REQ-026 Assert sys_rst mid-run with pending config -> next cycle all REQ-017 values; pending config discarded.
